// File: rtl/sm_fixed_pkg.sv
// Sign-magnitude fixed-point types and the reference add function used by the
// shared adder core.
package sm_fixed_pkg;

    localparam int SM_WIDTH = 16;

    typedef struct packed {
        logic                sign;
        logic [SM_WIDTH-2:0] mag;
    } sm_word_t;

    typedef struct packed {
        logic     ovf;
        sm_word_t word;
    } sm_sum_t;

    // Opposite signs with equal magnitudes collapse to +0, never -0.
    function automatic sm_sum_t sm_add(input sm_word_t a, input sm_word_t b);
        sm_sum_t             r;
        logic [SM_WIDTH-1:0] sum;
        r   = '0;
        sum = '0;
        if (a.sign == b.sign) begin
            sum         = {1'b0, a.mag} + {1'b0, b.mag};
            r.ovf       = sum[SM_WIDTH-1];
            r.word.sign = a.sign;
            r.word.mag  = sum[SM_WIDTH-2:0];
        end else if (a.mag > b.mag) begin
            r.word.sign = a.sign;
            r.word.mag  = a.mag - b.mag;
        end else if (b.mag > a.mag) begin
            r.word.sign = b.sign;
            r.word.mag  = b.mag - a.mag;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder. Uses the package function at the default
// width and an equivalent width-generic datapath otherwise.
module sm_add_core
    import sm_fixed_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    generate
        if (WIDTH == SM_WIDTH) begin : g_pkg
            sm_sum_t sum;
            assign sum    = sm_add(sm_word_t'(op1), sm_word_t'(op2));
            assign result = sum.word;
            assign ovf    = sum.ovf;
        end else begin : g_generic
            logic             sign1, sign2;
            logic [WIDTH-2:0] mag1, mag2;
            logic [WIDTH-1:0] mag_sum;

            assign sign1 = op1[WIDTH-1];
            assign sign2 = op2[WIDTH-1];
            assign mag1  = op1[WIDTH-2:0];
            assign mag2  = op2[WIDTH-2:0];

            // NOTE: every output of a combinational block gets a default first,
            // so no path through the if/else chain can infer a latch.
            always_comb begin
                result  = '0;
                ovf     = 1'b0;
                mag_sum = '0;
                if (sign1 == sign2) begin
                    mag_sum = {1'b0, mag1} + {1'b0, mag2};
                    ovf     = mag_sum[WIDTH-1];
                    result  = {sign1, mag_sum[WIDTH-2:0]};
                end else if (mag1 > mag2) begin
                    result = {sign1, mag1 - mag2};
                end else if (mag2 > mag1) begin
                    result = {sign2, mag2 - mag1};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder between NUM_REQ
// requesters, with a single registered valid/ready output stage.
module sm_add_arbiter
    import sm_fixed_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = SM_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op1_flat,
    input  logic [NUM_REQ*WIDTH-1:0] op2_flat,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     res_ovf,
    output logic [CNT_W-1:0]         served_cnt
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic                res_valid_q, res_valid_d;
    logic [WIDTH-1:0]    res_data_q,  res_data_d;
    logic [ID_W-1:0]     res_id_q,    res_id_d;
    logic                res_ovf_q,   res_ovf_d;
    logic [CNT_W-1:0]    served_cnt_q, served_cnt_d;
    logic [ID_W-1:0]     rr_q,        rr_d;

    logic [NUM_REQ-1:0]  req_rot;
    logic [ID_W-1:0]     prio_idx;
    logic [ID_W:0]       winner_sum;
    logic [ID_W-1:0]     winner;
    logic                accept;
    logic [WIDTH-1:0]    win_op1, win_op2;
    logic [WIDTH-1:0]    add_result;
    logic                add_ovf;

    // Rotate so that position 0 of req_rot is requester rr_q.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [ID_W:0] idx;
            idx = {1'b0, rr_q} + (ID_W+1)'(i);
            if (idx >= NUM_REQ_W) begin
                idx = idx - NUM_REQ_W;
            end
            req_rot[i] = req[idx[ID_W-1:0]];
        end
    end

    always_comb begin
        prio_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                prio_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        winner_sum = {1'b0, rr_q} + {1'b0, prio_idx};
        if (winner_sum >= NUM_REQ_W) begin
            winner_sum = winner_sum - NUM_REQ_W;
        end
        winner = winner_sum[ID_W-1:0];
    end

    // No grant while reset is held: nothing is captured on those edges.
    assign accept  = !rst && (|req) && (!res_valid_q || res_ready);
    assign gnt     = accept ? (NUM_REQ'(1) << winner) : '0;
    assign win_op1 = op1_flat[winner*WIDTH +: WIDTH];
    assign win_op2 = op2_flat[winner*WIDTH +: WIDTH];

    sm_add_core #(
        .WIDTH (WIDTH)
    ) u_add_core (
        .op1    (win_op1),
        .op2    (win_op2),
        .result (add_result),
        .ovf    (add_ovf)
    );

    always_comb begin
        rr_d         = rr_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        res_ovf_d    = res_ovf_q;
        served_cnt_d = served_cnt_q;
        if (accept) begin
            rr_d         = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
            res_valid_d  = 1'b1;
            res_data_d   = add_result;
            res_id_d     = winner;
            res_ovf_d    = add_ovf;
            served_cnt_d = served_cnt_q + CNT_W'(1);
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q         <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            res_ovf_q    <= 1'b0;
            served_cnt_q <= '0;
        end else begin
            rr_q         <= rr_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_ovf_q    <= res_ovf_d;
            served_cnt_q <= served_cnt_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;
    assign res_ovf    = res_ovf_q;
    assign served_cnt = served_cnt_q;

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Directed self-checking bench for sm_add_arbiter (4 requesters, 16-bit words,
// 4-bit served counter so that wrap-around is reachable quickly).
module tb_sm_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] op1_flat;
    logic [NUM_REQ*WIDTH-1:0] op2_flat;
    logic [NUM_REQ-1:0]       gnt;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_data;
    logic [ID_W-1:0]          res_id;
    logic                     res_ovf;
    logic [CNT_W-1:0]         served_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sm_add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op1_flat   (op1_flat),
        .op2_flat   (op2_flat),
        .gnt        (gnt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ovf    (res_ovf),
        .served_cnt (served_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op1_flat[i*WIDTH +: WIDTH] = a;
        op2_flat[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req       = '0;
        res_ready = 1'b1;
        rst       = 1'b1;
        #2;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        req       = '0;
        res_ready = 1'b1;
        op1_flat  = '0;
        op2_flat  = '0;
        rst       = 1'b1;
        #12;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", res_valid);
        end
        n_checks++;
        if (res_data !== 16'h0000 || res_id !== 2'd0 || res_ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_fields: got data=%h id=%0d ovf=%b want 0/0/0", res_data, res_id, res_ovf);
        end
        n_checks++;
        if (served_cnt !== 4'd0 || gnt !== 4'b0000) begin
            n_fail++; $display("FAIL reset_cnt_gnt: got cnt=%0d gnt=%b want 0/0000", served_cnt, gnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        set_ops(0, 16'h0003, 16'h0005);
        req = 4'b0001;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt);
        end
        @(negedge clk);
        req = '0;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0008 || res_id !== 2'd0 || res_ovf !== 1'b0) begin
            n_fail++; $display("FAIL single_result: got v=%b data=%h id=%0d ovf=%b want 1/0008/0/0",
                               res_valid, res_data, res_id, res_ovf);
        end
        n_checks++;
        if (served_cnt !== 4'd1) begin
            n_fail++; $display("FAIL single_cnt: got %0d want 1", served_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] exp_data;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_ops(i, 16'(i + 1), 16'h0010);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req = 4'b1111;
            if (k > 0) begin
                exp_data = 16'h0011 + 16'((k - 1) % 4);
                n_checks++;
                if (res_id !== 2'((k - 1) % 4) || res_data !== exp_data || res_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rr_result_%0d: got id=%0d data=%h v=%b want id=%0d data=%h v=1",
                                       k, res_id, res_data, res_valid, (k - 1) % 4, exp_data);
                end
            end
            #1;
            n_checks++;
            if (gnt !== (4'b0001 << (k % 4))) begin
                n_fail++; $display("FAIL rr_gnt_%0d: got %b want %b", k, gnt, 4'b0001 << (k % 4));
            end
        end
        @(negedge clk);
        req = '0;
        n_checks++;
        if (res_id !== 2'd3 || res_data !== 16'h0014 || served_cnt !== 4'd8) begin
            n_fail++; $display("FAIL rr_final: got id=%0d data=%h cnt=%0d want 3/0014/8", res_id, res_data, served_cnt);
        end
    endtask

    task automatic test_sign_cases();
        logic [WIDTH-1:0] a_tab   [5] = '{16'h0005, 16'h8007, 16'h0004, 16'h7FFF, 16'h8000};
        logic [WIDTH-1:0] b_tab   [5] = '{16'h8003, 16'h0002, 16'h8004, 16'h0001, 16'h8000};
        logic [WIDTH-1:0] exp_tab [5] = '{16'h0002, 16'h8005, 16'h0000, 16'h0000, 16'h8000};
        logic             ovf_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_ops(2, a_tab[k], b_tab[k]);
            req = 4'b0100;
            #1;
            n_checks++;
            if (gnt !== 4'b0100) begin
                n_fail++; $display("FAIL sign_gnt_%0d: got %b want 0100", k, gnt);
            end
            @(negedge clk);
            req = '0;
            n_checks++;
            if (res_data !== exp_tab[k] || res_ovf !== ovf_tab[k] || res_id !== 2'd2) begin
                n_fail++; $display("FAIL sign_case_%0d: %h+%h got data=%h ovf=%b id=%0d want %h/%b/2",
                                   k, a_tab[k], b_tab[k], res_data, res_ovf, res_id, exp_tab[k], ovf_tab[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        set_ops(1, 16'h0010, 16'h0001);
        set_ops(2, 16'h0020, 16'h8005);
        res_ready = 1'b0;
        req       = 4'b0110;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++; $display("FAIL bp_first_gnt: got %b want 0010", gnt);
        end
        @(negedge clk);
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_checks++;
            if (gnt !== 4'b0000 || res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'h0011 || served_cnt !== 4'd1) begin
                n_fail++; $display("FAIL bp_stall_%0d: got gnt=%b v=%b id=%0d data=%h cnt=%0d want 0000/1/1/0011/1",
                                   k, gnt, res_valid, res_id, res_data, served_cnt);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++; $display("FAIL bp_release_gnt: got %b want 0100", gnt);
        end
        @(negedge clk);
        req = '0;
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 16'h001B || served_cnt !== 4'd2) begin
            n_fail++; $display("FAIL bp_second: got v=%b id=%0d data=%h cnt=%0d want 1/2/001b/2",
                               res_valid, res_id, res_data, served_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        @(negedge clk);
        set_ops(0, 16'h0001, 16'h0001);
        set_ops(3, 16'h0002, 16'h0002);
        res_ready = 1'b0;
        req       = 4'b0001;
        @(negedge clk);
        req = '0;
        n_checks++;
        if (res_valid !== 1'b1 || served_cnt !== 4'd1) begin
            n_fail++; $display("FAIL mid_pre: got v=%b cnt=%0d want 1/1", res_valid, served_cnt);
        end
        #2;
        rst = 1'b1;
        req = 4'b1001;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || served_cnt !== 4'd0 || res_data !== 16'h0000 || gnt !== 4'b0000) begin
            n_fail++; $display("FAIL mid_async: got v=%b cnt=%0d data=%h gnt=%b want 0/0/0000/0000",
                               res_valid, served_cnt, res_data, gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL mid_rr_cleared: got %b want 0001", gnt);
        end
        req = 4'b1000;
        #1;
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++; $display("FAIL mid_after_gnt: got %b want 1000", gnt);
        end
        @(negedge clk);
        req       = '0;
        res_ready = 1'b1;
        n_checks++;
        if (res_id !== 2'd3 || res_data !== 16'h0004 || served_cnt !== 4'd1) begin
            n_fail++; $display("FAIL mid_after_result: got id=%0d data=%h cnt=%0d want 3/0004/1", res_id, res_data, served_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        @(negedge clk);
        set_ops(0, 16'h0001, 16'h0000);
        req = 4'b0001;
        repeat (17) @(negedge clk);
        req = '0;
        n_checks++;
        if (served_cnt !== 4'd1) begin
            n_fail++; $display("FAIL cnt_wrap: got %0d want 1", served_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_sign_cases();
        test_backpressure();
        test_reset_mid_stall();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_add_arbiter.md
Name: sm_add_arbiter

Overview:
- Shares one sign-magnitude fixed-point adder between NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair with a level request. The winner's pair goes through the adder into a registered output stage with valid/ready backpressure.
- Sits between the fixed-point compute clients and any downstream consumer of sums. This avoids instantiating one adder per client.

Parameters:
- NUM_REQ, 4: number of requesters; at least 2.
- WIDTH, 16: operand and result width. Bit WIDTH-1 is the sign; bits WIDTH-2..0 are the magnitude.
- ID_W, $clog2(NUM_REQ): requester index width.
- CNT_W, 16: width of the served-operation counter.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous reset, active-high.
- req, in, NUM_REQ: level request per requester. Held high, with operands stable, until that requester's gnt pulses.
- op1_flat, in, NUM_REQ*WIDTH: operand 1 of requester i at bits [i*WIDTH +: WIDTH].
- op2_flat, in, NUM_REQ*WIDTH: operand 2, same packing as op1_flat.
- gnt, out, NUM_REQ: one-hot or zero, combinational. gnt[i]=1 means requester i's operands are captured at this clock edge.
- res_valid, out, 1: the output register holds a result.
- res_ready, in, 1: the consumer accepts the result when res_valid && res_ready.
- res_data, out, WIDTH: sign-magnitude sum.
- res_id, out, ID_W: index of the requester that produced res_data.
- res_ovf, out, 1: magnitude carry-out occurred; res_data magnitude is truncated.
- served_cnt, out, CNT_W: count of accepted operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, all outputs): res_valid=0, res_data=0, res_id=0, res_ovf=0, served_cnt=0, rr pointer=0, gnt=0.
- Reset asserted mid-operation discards any held result. Requesters still asserting req are re-arbitrated after deassertion.
- Accept condition: `accept = (|req) && (!res_valid || res_ready)`. gnt is all-zero whenever accept=0.
- Arbitration: the winner is the first requester with req set, searching from index rr upward and wrapping modulo NUM_REQ.
- On accept, rr <= winner+1 modulo NUM_REQ. rr is unchanged when there is no accept.
- Output register on accept: res_data, res_id, res_ovf load from the adder applied to the winner's operands; res_valid <= 1; served_cnt increments.
- Latency: a result is visible one cycle after its gnt pulse.
- On a handshake with no accept in the same cycle, res_valid <= 0. Data fields hold their last value.
- Simultaneous drain and accept: the new result replaces the old one in the same edge, giving full throughput of one operation per cycle.
- Stall: while res_valid && !res_ready, there are no grants and the output fields are stable.
- Adder arithmetic (combinational):
  - Signs equal: sign = op1 sign; {ovf, mag} = mag1 + mag2 computed at WIDTH bits.
  - Signs differ, mag1 > mag2: sign = op1 sign; mag = mag1 - mag2.
  - Signs differ, mag2 > mag1: sign = op2 sign; mag = mag2 - mag1.
  - Signs differ, magnitudes equal: result is +0 (all bits 0).
  - ovf is 0 on every subtract path.
- Negative-zero inputs (sign=1, mag=0) are accepted as zero magnitude with sign 1. Same-sign addition of two -0 operands returns -0.
- served_cnt wraps from 2^CNT_W-1 to 0 without any flag.

Decomposition:
- Package sm_fixed_pkg holds:
  - the WIDTH default;
  - the sm_word_t struct {sign, mag};
  - the function sm_add(a, b) returning {ovf, sm_word_t}.
- One sub-module: sm_add_core, the combinational adder above with ports op1, op2, result, ovf. It is instantiated once.
- The arbiter (rotate, priority-encode, unrotate) stays inline in sm_add_arbiter.

Test Plan:
- Single request: req=0001, op1=0x0003, op2=0x0005 -> gnt=0001 that cycle. Next cycle res_valid=1, res_data=0x0008, res_id=0, res_ovf=0, served_cnt=1.
- All requesting, res_ready=1 held: req=1111 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one per cycle; served_cnt=8.
- Sign cases:
  - 0x0005 + 0x8003 -> 0x0002.
  - 0x8007 + 0x0002 -> 0x8005.
  - 0x0004 + 0x8004 -> 0x0000.
  - 0x7FFF + 0x0001 -> res_ovf=1, res_data=0x0000.
- Backpressure: res_ready=0 with req=0110 -> one grant (id 1), then gnt=0 and outputs stable for 3 cycles. When res_ready=1, id 2 is granted in the same cycle the first result drains.
- Reset mid-stall: assert rst asynchronously between edges while res_valid=1 -> res_valid=0, served_cnt=0, and rr=0 immediately. After release, req=1000 -> gnt=1000.
- Counter wrap: with CNT_W=4, perform 17 accepts -> served_cnt reads 1.
